// File: rtl/enum_t.sv
// Types shared by the i2c engine, its clients and the bus arbiter.
package enum_t;

   typedef enum logic [1:0] {
      EN_STOP,
      EN_START,
      EN_WR,
      EN_RD
   } en_t;

   typedef enum logic [2:0] {
      STOP,
      START,
      WR,
      RD,
      ACK,
      NACK
   } i2c_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DRAIN
   } arb_state_t;

   localparam int TIMEOUT_DEF = 2_000_000;

endpackage

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c engine between N_REQ client blocks.
// state | meaning
// IDLE  | no owner; wait for a request while the engine reports STOP
// GRANT | one client drives the engine; hold counter guards against hogging
// DRAIN | grant withdrawn, engine forced to EN_STOP until it settles at STOP
module i2c_arbiter
   import enum_t::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   output logic [N_REQ-1:0]       gnt,
   input  en_t  [N_REQ-1:0]       cl_en,
   input  logic [N_REQ-1:0][7:0]  cl_data,
   output en_t                    eng_en,
   output logic [7:0]             eng_data,
   input  i2c_t                   eng_st,
   input  logic [7:0]             eng_out,
   output i2c_t                   cl_st,
   output logic [7:0]             cl_out,
   output logic                   tmo
);

   localparam int          IW        = (N_REQ > 2) ? 2 : 1;
   localparam logic [31:0] HOLD_LAST = 32'(TIMEOUT - 1);

   arb_state_t     state;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  sel;
   logic [31:0]    hold_cnt;
   logic           pick_ok;
   logic [IW-1:0]  pick_idx;

   // Search begins one past the last owner so a released client goes to the back.
   function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                           input logic [IW-1:0]    last);
      logic          found;
      logic [IW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         j = (int'(last) + i) % N_REQ;
         if (!found && r[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
      return {found, idx};
   endfunction

   assign {pick_ok, pick_idx} = rr_pick(req, ptr);

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         tmo      <= 1'b0;
         hold_cnt <= '0;
         ptr      <= IW'(N_REQ - 1);
         sel      <= '0;
      end else begin
         tmo <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_ok && eng_st == STOP) begin
                  state    <= GRANT;
                  sel      <= pick_idx;
                  gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (!req[sel] || hold_cnt == HOLD_LAST) begin
                  state <= DRAIN;
                  gnt   <= '0;
                  // a voluntary release in the same cycle is not a timeout
                  tmo   <= req[sel];
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 32'd1;
               end
            end
            DRAIN: begin
               if (eng_st == STOP) begin
                  state <= IDLE;
                  ptr   <= sel;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      eng_en   = EN_STOP;
      eng_data = '0;
      if (state == GRANT) begin
         eng_en   = cl_en[sel];
         eng_data = cl_data[sel];
      end
   end

   assign cl_st  = eng_st;
   assign cl_out = eng_out;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: a behavioural model predicts the owner
// and timeout pulse each falling edge; a monitor checks the DUT on rising edges.
module tb_i2c_arbiter;
   import enum_t::*;

   localparam int N   = 3;
   localparam int TMO = 100;

   logic              clk = 1'b1;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N-1:0]      gnt;
   en_t  [N-1:0]      cl_en;
   logic [N-1:0][7:0] cl_data;
   en_t               eng_en;
   logic [7:0]        eng_data;
   i2c_t              eng_st = STOP;
   logic [7:0]        eng_out;
   i2c_t              cl_st;
   logic [7:0]        cl_out;
   logic              tmo;

   int vectors     = 0;
   int miscompares = 0;
   int len [N];

   typedef struct {
      int   owner;
      logic tmo;
   } exp_t;
   exp_t sb[$];

   i2c_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .cl_en(cl_en), .cl_data(cl_data),
      .eng_en(eng_en), .eng_data(eng_data),
      .eng_st(eng_st), .eng_out(eng_out),
      .cl_st(cl_st), .cl_out(cl_out), .tmo(tmo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Reference model: who owns the bus, whether the grant is being drained,
   // and how many cycles the current owner has held it.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_held  = 0;
   bit m_drain = 1'b0;

   always @(negedge clk) begin
      logic t;
      int   c;
      bit   found;
      t = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_drain = 1'b0;
         m_last  = N - 1;
         m_held  = 0;
      end else if (m_owner >= 0 && !m_drain) begin
         if (!req[m_owner]) m_drain = 1'b1;
         else if (m_held == TMO) begin
            m_drain = 1'b1;
            t       = 1'b1;
         end else m_held++;
      end else if (m_owner >= 0) begin
         if (eng_st == STOP) begin
            m_last  = m_owner;
            m_owner = -1;
            m_drain = 1'b0;
         end
      end else if (req != '0 && eng_st == STOP) begin
         found = 1'b0;
         for (int d = 1; d <= N; d++) begin
            c = (m_last + d) % N;
            if (!found && req[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_held  = 1;
            end
         end
      end
      sb.push_back('{m_drain ? -1 : m_owner, t});
   end

   always @(posedge clk) begin
      exp_t         e;
      logic [N-1:0] eg;
      en_t          ee;
      logic [7:0]   ed;
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         eg = '0;
         ee = EN_STOP;
         ed = '0;
         if (e.owner >= 0) begin
            eg[e.owner] = 1'b1;
            ee = cl_en[e.owner];
            ed = cl_data[e.owner];
         end
         check("gnt", 32'(gnt), 32'(eg));
         check("tmo", 32'(tmo), 32'(e.tmo));
         check("eng_en", 32'(eng_en), 32'(ee));
         check("eng_data", 32'(eng_data), 32'(ed));
         check("cl_st", 32'(cl_st), 32'(eng_st));
         check("cl_out", 32'(cl_out), 32'(eng_out));
      end
   end

   task automatic rand_data();
      for (int i = 0; i < N; i++) begin
         cl_en[i]   = en_t'($urandom_range(0, 3));
         cl_data[i] = 8'($urandom);
      end
      eng_out = 8'($urandom);
   endtask

   task automatic cyc(input logic [N-1:0] r, input i2c_t st, input int n);
      for (int i = 0; i < n; i++) begin
         req    = r;
         eng_st = st;
         rand_data();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rand_data();
      cl_en[0] = EN_WR;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_eng_en", 32'(eng_en), 32'(EN_STOP));
      check("rst_eng_data", 32'(eng_data), 32'd0);
      check("rst_tmo", 32'(tmo), 32'd0);
      rst = 1'b0;

      cyc(3'b001, STOP, 6);
      cyc(3'b000, STOP, 3);

      cyc(3'b011, STOP, 5);
      cyc(3'b010, WR, 3);
      cyc(3'b010, STOP, 6);
      cyc(3'b000, STOP, 3);

      for (int k = 0; k < 3; k++) begin
         cyc(3'b011, STOP, 4);
         cyc(3'b010, STOP, 4);
      end
      cyc(3'b000, STOP, 3);

      cyc(3'b001, WR, 5);
      cyc(3'b001, STOP, 4);
      cyc(3'b000, STOP, 3);

      cyc(3'b001, STOP, 105);
      cyc(3'b011, STOP, 110);
      cyc(3'b000, STOP, 4);

      cyc(3'b001, STOP, 4);
      eng_st = WR;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_gnt", 32'(gnt), 32'd0);
      check("async_rst_eng_en", 32'(eng_en), 32'(EN_STOP));
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(3'b001, WR, 5);
      cyc(3'b001, STOP, 4);
      cyc(3'b000, STOP, 3);

      for (int i = 0; i < N; i++) len[i] = 0;
      for (int cy = 0; cy < 3000; cy++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  len[i] = ($urandom_range(0, 49) == 0) ? 130 : int'($urandom_range(1, 8));
               end
            end else if (gnt[i]) begin
               if (len[i] > 0) len[i]--;
               if (len[i] == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
         eng_st = ($urandom_range(0, 9) < 6) ? STOP : (($urandom_range(0, 1) == 0) ? WR : RD);
         rst    = (cy == 1500);
         rand_data();
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      cyc(3'b000, STOP, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
